// File: rtl/local_sram_writer.sv
// Accepts 128-bit local write beats and commits them to a single-port SRAM window.
// Define LOCAL_SRAM_RMW_EN to merge partial-strobe beats by read-modify-write instead of byte enables.
`timescale 1ns/1ps
module local_sram_writer #(
  parameter int          AWID  = 12,
  parameter logic [31:0] BASE  = 32'h0000_0000,
  parameter int          IDWID = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              local_wr,
  input  logic              local_last,
  input  logic [31:0]       local_addr,
  input  logic [127:0]      local_wr_data,
  input  logic [15:0]       local_wstrb,
  input  logic [IDWID-1:0]  local_wid,
  output logic              local_wr_ok,
  output logic              local_wr_error,
  output logic              sram_en,
  output logic              sram_we,
  output logic [AWID-1:0]   sram_addr,
  output logic [127:0]      sram_wdata,
  output logic [15:0]       sram_be,
  input  logic [127:0]      sram_rdata,
  output logic [15:0]       wr_bursts,
  output logic [IDWID-1:0]  last_wid,
  output logic              busy
);

`ifdef LOCAL_SRAM_RMW_EN
  typedef enum logic [1:0] {IDLE, WR, RD, MG} state_t;
`else
  typedef enum logic [0:0] {IDLE, WR} state_t;
`endif

  localparam logic [31:0] WIN_MASK = ~((32'd1 << (AWID + 4)) - 32'd1);

  state_t            state, next_state;
  logic              rst_q;
  logic [AWID-1:0]   cap_addr;
  logic [127:0]      cap_data;
  logic [15:0]       cap_be;
  logic              cap_last;
  logic [IDWID-1:0]  cap_wid;
  logic              in_win, accept, access, drop_last, wr_last_done;
  logic [15:0]       burst_inc;

  // The extra post-reset cycle keeps upstream stalled while the block settles
  assign local_wr_ok    = !rst && !rst_q && (state == IDLE || state == WR);
  assign in_win         = (local_addr & WIN_MASK) == BASE;
  assign accept         = local_wr && local_wr_ok;
  assign access         = accept && in_win && (local_wstrb != 16'h0000);
  assign local_wr_error = accept && !in_win;
  assign drop_last      = accept && local_last && !(in_win && (local_wstrb != 16'h0000));
  assign wr_last_done   = (state == WR) && cap_last;
  assign burst_inc      = 16'(wr_last_done) + 16'(drop_last);

`ifdef LOCAL_SRAM_RMW_EN
  logic [15:0]  cap_strb;
  logic [127:0] merged;

  assign sram_en = !rst && (state == WR || state == RD);

  always_comb begin
    merged = '0;
    for (int b = 0; b < 16; b++) begin
      merged[8*b +: 8] = cap_strb[b] ? cap_data[8*b +: 8] : sram_rdata[8*b +: 8];
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^sram_rdata;
  assign sram_en      = !rst && (state == WR);
`endif

  assign sram_we    = !rst && (state == WR);
  assign busy       = !rst && (state != IDLE);
  assign sram_addr  = cap_addr;
  assign sram_wdata = cap_data;
  assign sram_be    = cap_be;

  always_comb begin
    next_state = state;
    case (state)
      IDLE, WR: begin
        next_state = IDLE;
`ifdef LOCAL_SRAM_RMW_EN
        if (access) next_state = (local_wstrb == 16'hFFFF) ? WR : RD;
`else
        if (access) next_state = WR;
`endif
      end
`ifdef LOCAL_SRAM_RMW_EN
      RD:      next_state = MG;
      MG:      next_state = WR;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rst_q     <= 1'b1;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_be    <= '0;
      cap_last  <= 1'b0;
      cap_wid   <= '0;
      wr_bursts <= '0;
      last_wid  <= '0;
`ifdef LOCAL_SRAM_RMW_EN
      cap_strb  <= '0;
`endif
    end else begin
      state <= next_state;
      rst_q <= 1'b0;
      if (access) begin
        cap_addr <= local_addr[AWID+3:4];
        cap_data <= local_wr_data;
        cap_last <= local_last;
        cap_wid  <= local_wid;
`ifdef LOCAL_SRAM_RMW_EN
        cap_be   <= 16'hFFFF;
        cap_strb <= local_wstrb;
`else
        cap_be   <= local_wstrb;
`endif
      end
`ifdef LOCAL_SRAM_RMW_EN
      if (state == MG) cap_data <= merged;
`endif
      // A dropped beat in the same cycle was accepted after the one being written
      if (wr_last_done || drop_last) begin
        wr_bursts <= wr_bursts + burst_inc;
        last_wid  <= drop_last ? local_wid : cap_wid;
      end
    end
  end

endmodule

// File: tb/tb_local_sram_writer.sv
// Directed self-checking bench for local_sram_writer with a behavioural SRAM model.
`timescale 1ns/1ps
module tb_local_sram_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         local_wr, local_last;
  logic [31:0]  local_addr;
  logic [127:0] local_wr_data;
  logic [15:0]  local_wstrb;
  logic [7:0]   local_wid;
  logic         local_wr_ok, local_wr_error;
  logic         sram_en, sram_we;
  logic [11:0]  sram_addr;
  logic [127:0] sram_wdata, sram_rdata;
  logic [15:0]  sram_be;
  logic [15:0]  wr_bursts;
  logic [7:0]   last_wid;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int wsnap;

  logic [127:0] mem [0:4095];

  localparam logic [127:0] MERGED = {{12{8'hAA}}, {4{8'h55}}};

  local_sram_writer dut (
    .clk(clk), .rst(rst),
    .local_wr(local_wr), .local_last(local_last), .local_addr(local_addr),
    .local_wr_data(local_wr_data), .local_wstrb(local_wstrb), .local_wid(local_wid),
    .local_wr_ok(local_wr_ok), .local_wr_error(local_wr_error),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_be(sram_be), .sram_rdata(sram_rdata),
    .wr_bursts(wr_bursts), .last_wid(last_wid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: byte-enabled write, one-cycle read latency
  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      writes <= writes + 1;
      for (int b = 0; b < 16; b++) begin
        if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end else if (sram_en) begin
      sram_rdata <= mem[sram_addr];
    end
  end

  function automatic logic [127:0] beatData(input int k);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(k);
    return {4{w}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic last, input logic [31:0] addr,
                               input logic [127:0] data, input logic [15:0] strb, input logic [7:0] wid);
    local_wr      = wr;
    local_last    = last;
    local_addr    = addr;
    local_wr_data = data;
    local_wstrb   = strb;
    local_wid     = wid;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle;
    applyStimulus(1'b0, 1'b0, 32'h0, 128'h0, 16'h0, 8'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0001_0000, 128'h0, 16'hFFFF, 8'h01);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_ok", local_wr_ok, 0);
    checkOutput("rst_error", local_wr_error, 0);
    checkOutput("rst_en", sram_en, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    idle();
    checkOutput("post_rst_wr_ok", local_wr_ok, 0);
    checkOutput("post_rst_addr", sram_addr, 0);
    checkOutput("post_rst_wdata", sram_wdata, 0);
    checkOutput("post_rst_be", sram_be, 0);
    checkOutput("post_rst_bursts", wr_bursts, 0);
    checkOutput("post_rst_wid", last_wid, 0);
    tick();
    checkOutput("idle_wr_ok", local_wr_ok, 1);

    // Four-beat full-strobe burst, one beat per cycle
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, k == 3, 32'h100 + 32'(16 * k), beatData(k), 16'hFFFF, 8'h11);
      checkOutput("burst_wr_ok", local_wr_ok, 1);
      checkOutput("burst_en", sram_en, k > 0);
      if (k > 0) begin
        checkOutput("burst_addr", sram_addr, 12'h10 + 12'(k - 1));
        checkOutput("burst_wdata", sram_wdata, beatData(k - 1));
      end
      tick();
    end
    idle();
    checkOutput("burst_last_en", sram_en, 1);
    checkOutput("burst_last_we", sram_we, 1);
    checkOutput("burst_last_addr", sram_addr, 12'h13);
    checkOutput("burst_last_be", sram_be, 16'hFFFF);
    tick();
    checkOutput("burst_done_en", sram_en, 0);
    checkOutput("burst_done_busy", busy, 0);
    checkOutput("burst_count", wr_bursts, 1);
    checkOutput("burst_wid", last_wid, 8'h11);
    checkOutput("burst_mem", mem[12'h12], beatData(2));
    checkOutput("burst_writes", writes, 4);

    // Zero-strobe beat is consumed silently but still closes its burst
    applyStimulus(1'b1, 1'b1, 32'h300, 128'h0, 16'h0000, 8'h22);
    checkOutput("zstrb_ok", local_wr_ok, 1);
    checkOutput("zstrb_error", local_wr_error, 0);
    tick();
    idle();
    checkOutput("zstrb_en", sram_en, 0);
    checkOutput("zstrb_count", wr_bursts, 2);
    checkOutput("zstrb_wid", last_wid, 8'h22);

    // Top word of the window is still in range
    applyStimulus(1'b1, 1'b0, 32'h0000_FFF0, beatData(9), 16'hFFFF, 8'h00);
    checkOutput("top_error", local_wr_error, 0);
    tick();
    idle();
    checkOutput("top_en", sram_en, 1);
    checkOutput("top_addr", sram_addr, 12'hFFF);
    tick();

    // First byte beyond the window
    applyStimulus(1'b1, 1'b1, 32'h0001_0000, beatData(3), 16'hFFFF, 8'h33);
    checkOutput("oow_error", local_wr_error, 1);
    tick();
    idle();
    checkOutput("oow_en", sram_en, 0);
    checkOutput("oow_busy", busy, 0);
    checkOutput("oow_count", wr_bursts, 3);
    checkOutput("oow_wid", last_wid, 8'h33);
    checkOutput("oow_writes", writes, 5);

    // Full write then partial write to the same word, back to back
    applyStimulus(1'b1, 1'b0, 32'h200, {16{8'hAA}}, 16'hFFFF, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 32'h200, {16{8'h55}}, 16'h000F, 8'h44);
    checkOutput("part_ok", local_wr_ok, 1);
    checkOutput("part_full_en", sram_en, 1);
    tick();
    idle();
`ifdef LOCAL_SRAM_RMW_EN
    checkOutput("rmw_rd_en", sram_en, 1);
    checkOutput("rmw_rd_we", sram_we, 0);
    checkOutput("rmw_rd_ok", local_wr_ok, 0);
    checkOutput("rmw_rd_addr", sram_addr, 12'h20);
    tick();
    checkOutput("rmw_mg_en", sram_en, 0);
    checkOutput("rmw_mg_ok", local_wr_ok, 0);
    checkOutput("rmw_mg_busy", busy, 1);
    tick();
    checkOutput("rmw_wr_we", sram_we, 1);
    checkOutput("rmw_wr_be", sram_be, 16'hFFFF);
    checkOutput("rmw_wr_data", sram_wdata, MERGED);
`else
    checkOutput("part_wr_we", sram_we, 1);
    checkOutput("part_wr_be", sram_be, 16'h000F);
    checkOutput("part_wr_data", sram_wdata, {16{8'h55}});
`endif
    tick();
    checkOutput("part_mem", mem[12'h20], MERGED);
    checkOutput("part_count", wr_bursts, 4);
    checkOutput("part_wid", last_wid, 8'h44);

    // Reset in the middle of an in-flight beat
`ifdef LOCAL_SRAM_RMW_EN
    applyStimulus(1'b1, 1'b1, 32'h400, beatData(5), 16'h00F0, 8'h66);
    tick();
    idle();
    tick();
`else
    applyStimulus(1'b1, 1'b1, 32'h400, beatData(5), 16'hFFFF, 8'h66);
    tick();
    idle();
`endif
    checkOutput("inflight_busy", busy, 1);
    wsnap = writes;
    rst = 1'b1;
    #1;
    checkOutput("abort_en", sram_en, 0);
    checkOutput("abort_busy", busy, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("abort_wr_ok", local_wr_ok, 0);
    checkOutput("abort_count", wr_bursts, 0);
    checkOutput("abort_wid", last_wid, 0);
    checkOutput("abort_addr", sram_addr, 0);
    tick();
    checkOutput("abort_writes", writes, wsnap);
    checkOutput("abort_idle_en", sram_en, 0);
    checkOutput("abort_idle_ok", local_wr_ok, 1);

    // Drive the burst counter to its limit, then wrap it with a written beat
    applyStimulus(1'b1, 1'b1, 32'h500, 128'h0, 16'h0000, 8'h5A);
    repeat (65535) tick();
    idle();
    checkOutput("sat_count", wr_bursts, 16'hFFFF);
    checkOutput("sat_wid", last_wid, 8'h5A);
    applyStimulus(1'b1, 1'b1, 32'h600, beatData(7), 16'hFFFF, 8'h77);
    tick();
    idle();
    checkOutput("wrap_pending", wr_bursts, 16'hFFFF);
    tick();
    checkOutput("wrap_count", wr_bursts, 16'h0000);
    checkOutput("wrap_wid", last_wid, 8'h77);
    checkOutput("wrap_mem", mem[12'h60], beatData(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
